approx_mul_seq_ctrl: RTL and testbench
======================================

// Module: approx_mul_seq_ctrl
// PURPOSE
//  Sequencing controller for a 4x4 multiply built from ONE time-shared 2x2 cell.
//  It accepts an operand pair over a valid/ready handshake and drives the cell through four partial products.
//  Each partial product is shifted and accumulated, and the 8-bit product is returned over a valid/ready handshake.
//  It is the area-reduced counterpart to the four-cell combinational approximate multiplier in the multiplier-array flow.
// PARAMETERS
//  APPROX  1  1: approximate 2x2 cell (3-bit output); 0: exact 2x2 cell (4-bit output)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  abort      in   1  synchronous abort: drop the current operation and return to IDLE
//  in_valid   in   1  operand pair valid
//  in_ready   out  1  controller can accept an operand pair
//  in_x       in   4  multiplicand
//  in_y       in   4  multiplier
//  out_valid  out  1  product valid
//  out_ready  in   1  consumer accepts the product
//  out_p      out  8  product
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; acc=0; step=0.
//   - out_valid=0, out_p=0, busy=0; in_ready=1 once rst deasserts.
//  Cell function, operands a[1:0] and b[1:0]:
//   - APPROX=1: c[2]=a1&b1, c[1]=(a0&b1)|(a1&b0), c[0]=a1&b0.
//   - APPROX=0: c=a*b (4 bits).
//  Step schedule:
//   - step0: a=x[1:0], b=y[1:0], shift 0.
//   - step1: a=x[1:0], b=y[3:2], shift 2.
//   - step2: a=x[3:2], b=y[1:0], shift 2.
//   - step3: a=x[3:2], b=y[3:2], shift 4.
//  Arithmetic: acc <= acc + (c << shift), 8-bit and unsigned; cannot overflow (max 175 approx / 225 exact).
//  States:
//   - IDLE: in_ready=1. On in_valid: latch x and y, acc<=0, step<=0, go to RUN.
//   - RUN: one step per cycle, step increments each cycle. After step3, go to DONE.
//   - DONE: out_valid=1, out_p=acc.
//     * out_ready=0: hold out_p and out_valid stable.
//     * out_ready=1, in_valid=0: go to IDLE.
//     * out_ready=1, in_valid=1: accept the new operands and go directly to RUN (back-to-back).
//  in_ready = (state==IDLE) | (state==DONE & out_ready) ; combinational, never depends on in_valid.
//  Latency and throughput:
//   - out_valid rises exactly 5 clock edges after the accepting edge (edge+1..+4 run steps 0..3; DONE at edge+5).
//   - Minimum initiation interval is 5 cycles.
//  Operands are latched at acceptance; in_x and in_y changes during RUN or DONE have no effect.
//  abort=1:
//   - Takes effect at the next edge from any state: go to IDLE, out_valid=0, acc=0.
//   - Abort wins over a simultaneous accept; in_ready is forced to 0 while abort=1.
//   - A product pending in DONE is discarded.
//  rst asserted mid-RUN or in DONE: immediate return to reset values; no partial result is presented.
//  out_p is registered and changes only on entry to DONE; it holds its last value after leaving DONE.
// TESTING
//  T1 APPROX=1, x=15, y=15: out_p=175 (each cell 7) exactly 5 edges after accept; in_ready=0 during RUN.
//  T2 APPROX=1, x=3,y=3 -> 7; x=2,y=1 -> 3; x=0,y=15 -> 0. Then APPROX=0, x=15,y=15 -> 225 and x=3,y=3 -> 9.
//  T3 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_p and out_valid stable, in_ready=0, nothing lost.
//  T4 Back-to-back, in_valid held high: x=5,y=6 then x=15,y=15 (APPROX=0) -> 30 then 225, 5-cycle spacing.
//  T5 abort in RUN step1 -> IDLE the next cycle with no out_valid; the next op x=7,y=9 (APPROX=0) -> 63.
//     abort together with in_valid in IDLE -> no accept.
//  T6 rst pulse mid-RUN and during DONE with out_ready=0 -> all outputs at reset values; the following op is correct.
//     Also compare all 256 operand pairs against the cell-formula model, both APPROX settings.

Source files
------------

// File: rtl/approx_mul_seq_ctrl.sv
// approx_mul_seq_ctrl
// Sequencing controller for a 4x4 unsigned multiply built from one time-shared
// 2x2 cell. Operands arrive over a valid/ready handshake. Four partial
// products are shifted and accumulated, one per cycle. The 8-bit product
// leaves over a second valid/ready handshake.
// Timing: the accepting edge enters RUN. The next four edges execute steps 0..3.
// One further edge registers the product and enters DONE, so out_valid rises
// 5 edges after acceptance.
module approx_mul_seq_ctrl #(
  parameter bit APPROX = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_p,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step value at which all four partial products are in acc.
  localparam logic [2:0] STEP_LAST = 3'd4;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic [7:0] acc;
  logic [2:0] step;
  logic       accept;
  logic [1:0] cell_a;
  logic [1:0] cell_b;
  logic [3:0] cell_c;
  logic [2:0] shamt;
  logic [7:0] pp;

  // The ready signal is purely a function of state, out_ready and abort.
  // Abort blocks any acceptance in the same cycle.
  assign in_ready  = ~abort & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand selection for the current step.
  // step[1] picks the x half, step[0] picks the y half, and the shift equals
  // twice the number of upper halves selected.
  always_comb begin
    cell_a = step[1] ? x_q[3:2] : x_q[1:0];
    cell_b = step[0] ? y_q[3:2] : y_q[1:0];
    shamt  = {step[1] & step[0], step[1] ^ step[0], 1'b0};
  end

  // 2x2 cell, approximate or exact depending on APPROX.
  generate
    if (APPROX) begin : g_approx
      assign cell_c = {1'b0,
                       cell_a[1] & cell_b[1],
                       (cell_a[0] & cell_b[1]) | (cell_a[1] & cell_b[0]),
                       cell_a[1] & cell_b[0]};
    end else begin : g_exact
      assign cell_c = {2'b00, cell_a} * {2'b00, cell_b};
    end
  endgenerate

  assign pp = {4'b0000, cell_c} << shamt;

  // Next-state logic. An abort overrides every other transition.
  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (step == STEP_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, step counter, accumulator and product register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the operand latches are reset even though acceptance always
    // overwrites them before use. This keeps the datapath deterministic
    // straight out of reset.
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      acc   <= '0;
      step  <= '0;
      out_p <= '0;
    end else if (abort) begin
      acc  <= '0;
      step <= '0;
    end else if (accept) begin
      x_q  <= in_x;
      y_q  <= in_y;
      acc  <= '0;
      step <= '0;
    end else if (state == RUN) begin
      if (step == STEP_LAST) begin
        out_p <= acc;
      end else begin
        acc  <= acc + pp;
        step <= step + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// Testbench for approx_mul_seq_ctrl.
// Two instances share all inputs: one uses the approximate cell, one uses the exact cell.
// Expected products are queued when an operand pair is accepted.
// They are popped and compared when the product is handed over.
module tb_approx_mul_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       in_valid;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       out_ready;
  logic       ir1, ov1, busy1;
  logic       ir0, ov0, busy0;
  logic [7:0] p1, p0;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  approx_mul_seq_ctrl #(.APPROX(1'b1)) u_approx (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(ir1),
    .in_x(in_x), .in_y(in_y), .out_valid(ov1), .out_ready(out_ready),
    .out_p(p1), .busy(busy1)
  );

  approx_mul_seq_ctrl #(.APPROX(1'b0)) u_exact (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(ir0),
    .in_x(in_x), .in_y(in_y), .out_valid(ov0), .out_ready(out_ready),
    .out_p(p0), .busy(busy0)
  );

  // Reference 2x2 cell, written bit by bit from the cell equations.
  function automatic int cell_m(input logic [1:0] a, input logic [1:0] b, input bit ap);
    int r;
    if (ap) r = 4 * int'(a[1] & b[1]) + 2 * int'((a[0] & b[1]) | (a[1] & b[0])) + int'(a[1] & b[0]);
    else    r = int'(a) * int'(b);
    return r;
  endfunction

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y, input bit ap);
    int s;
    s = cell_m(x[1:0], y[1:0], ap) + 4 * cell_m(x[1:0], y[3:2], ap)
      + 4 * cell_m(x[3:2], y[1:0], ap) + 16 * cell_m(x[3:2], y[3:2], ap);
    return s[7:0];
  endfunction

  // Offer an operand pair until accepted, pushing the given expectations.
  // Returns #1 after the accepting edge with in_valid low.
  task automatic send_exp(input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] e1, input logic [7:0] e0);
    int n;
    n = 0;
    in_x = x; in_y = y; in_valid = 1'b1;
    #1;
    while (!ir1 && n < 50) begin @(negedge clk); n++; end
    if (!ir1) begin
      checks++; failures++;
      $display("FAIL accept_timeout x=%0d y=%0d in_ready=%b required 1", x, y, ir1);
    end else begin
      q1.push_back(e1);
      q0.push_back(e0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y);
    send_exp(x, y, model(x, y, 1'b1), model(x, y, 1'b0));
  endtask

  // Wait for out_valid, compare both products, then hand them over.
  task automatic receive(input string name);
    int n;
    logic [7:0] e1, e0;
    n = 0;
    out_ready = 1'b1;
    while (!ov1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!ov1 || !ov0 || q1.size() == 0) begin
      failures++;
      $display("FAIL %s out_valid approx=%b exact=%b queued=%0d required 1/1/>0", name, ov1, ov0, q1.size());
    end else begin
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      checks++;
      if (p1 !== e1) begin
        failures++;
        $display("FAIL %s approx x=%0d y=%0d out_p=%0d required %0d", name, in_x, in_y, p1, e1);
      end
      checks++;
      if (p0 !== e0) begin
        failures++;
        $display("FAIL %s exact x=%0d y=%0d out_p=%0d required %0d", name, in_x, in_y, p0, e0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!ov1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!ov1) begin
      failures++;
      $display("FAIL %s wait out_valid=%b required 1", name, ov1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    #12;
    checks++;
    if ({ov1, ov0, busy1, busy0, p1, p0} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs ov=%b%b busy=%b%b p=%0d/%0d required all 0", ov1, ov0, busy1, busy0, p1, p0);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (ir1 !== 1'b1 || ir0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready in_ready=%b%b required 11", ir1, ir0);
    end
  endtask

  // T1 latency/in_ready, T2 directed products.
  task automatic test_basic();
    out_ready = 1'b0;
    send_exp(4'd15, 4'd15, 8'd175, 8'd225);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov1 !== (i == 5) || ov0 !== (i == 5)) begin
        failures++;
        $display("FAIL latency edge+%0d out_valid=%b%b required %b", i, ov1, ov0, (i == 5));
      end
      if (i < 5) begin
        checks++;
        if (ir1 !== 1'b0 || busy1 !== 1'b1) begin
          failures++;
          $display("FAIL run_flags edge+%0d in_ready=%b busy=%b required 0/1", i, ir1, busy1);
        end
      end
    end
    receive("t1_15x15");
    send_exp(4'd3, 4'd3, 8'd7, 8'd9);  receive("t2_3x3");
    send_exp(4'd2, 4'd1, 8'd3, 8'd2);  receive("t2_2x1");
    send_exp(4'd0, 4'd15, 8'd0, 8'd0); receive("t2_0x15");
  endtask

  task automatic test_backpressure();
    logic [7:0] h1, h0;
    out_ready = 1'b0;
    send(4'd11, 4'd13);
    wait_valid("bp");
    h1 = p1; h0 = p0;
    in_x = 4'd1; in_y = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov1 !== 1'b1 || ir1 !== 1'b0 || p1 !== h1 || p0 !== h0) begin
        failures++;
        $display("FAIL backpressure cyc%0d ov=%b in_ready=%b p=%0d/%0d required 1/0/%0d/%0d", i, ov1, ir1, p1, p0, h1, h0);
      end
    end
    in_valid = 1'b0; in_x = 4'd11; in_y = 4'd13;
    receive("bp_release");
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1, e0;
    int n;
    out_ready = 1'b1;
    in_x = 4'd5; in_y = 4'd6; in_valid = 1'b1;
    #1;
    q1.push_back(model(4'd5, 4'd6, 1'b1));
    q0.push_back(8'd30);
    @(posedge clk); #1;
    in_x = 4'd15; in_y = 4'd15;
    wait_valid("b2b_first");
    e1 = q1.pop_front(); e0 = q0.pop_front();
    checks++;
    if (p1 !== e1 || p0 !== e0 || ir1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first p=%0d/%0d in_ready=%b required %0d/%0d/1", p1, p0, ir1, e1, e0);
    end
    q1.push_back(8'd175);
    q0.push_back(8'd225);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL b2b_spacing edges=%0d required 5", n);
    end
    receive("b2b_second");
  endtask

  task automatic test_abort();
    logic seen;
    out_ready = 1'b1;
    send(4'd7, 4'd9);
    @(posedge clk); #1;
    abort = 1'b1; #1;
    checks++;
    if (ir1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_ready in_ready=%b required 0", ir1);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    void'(q1.pop_back()); void'(q0.pop_back());
    checks++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0 || ov1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b%b ov=%b required 00/0", busy1, busy0, ov1);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; seen |= ov1 | ov0; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_output out_valid_seen=%b required 0", seen);
    end
    send_exp(4'd7, 4'd9, model(4'd7, 4'd9, 1'b1), 8'd63);
    receive("after_abort_7x9");
    abort = 1'b1; in_valid = 1'b1; in_x = 4'd3; in_y = 4'd3; #1;
    checks++;
    if (ir1 !== 1'b0 || ir0 !== 1'b0) begin
      failures++;
      $display("FAIL abort_accept in_ready=%b%b required 00", ir1, ir0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL abort_accept_busy busy=%b%b required 00", busy1, busy0);
    end
    abort = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1;
    send(4'd9, 4'd13);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    checks++;
    if ({ov1, ov0, busy1, busy0, p1, p0} !== 20'd0) begin
      failures++;
      $display("FAIL rst_run ov=%b%b busy=%b%b p=%0d/%0d required all 0", ov1, ov0, busy1, busy0, p1, p0);
    end
    @(negedge clk); rst = 1'b0;
    q1.delete(); q0.delete();
    out_ready = 1'b0;
    send(4'd9, 4'd13);
    wait_valid("rst_done_setup");
    @(posedge clk); #3;
    rst = 1'b1; #1;
    checks++;
    if ({ov1, ov0, busy1, busy0, p1, p0} !== 20'd0) begin
      failures++;
      $display("FAIL rst_done ov=%b%b busy=%b%b p=%0d/%0d required all 0", ov1, ov0, busy1, busy0, p1, p0);
    end
    @(negedge clk); rst = 1'b0; #1;
    q1.delete(); q0.delete();
    checks++;
    if (ir1 !== 1'b1) begin
      failures++;
      $display("FAIL rst_release in_ready=%b required 1", ir1);
    end
    send(4'd11, 4'd6);
    receive("after_rst_11x6");
  endtask

  task automatic test_exhaustive();
    out_ready = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        send(x[3:0], y[3:0]);
        receive("sweep");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
